// File: rtl/zapper_hit_detector.sv
// zapper_hit_detector
// Light-gun receive side of the display path. A debounced trigger pull
// requests one all-black frame, then TARGET_FRAMES frames in which only the
// target box is lit. The photodiode is sampled during the target frames, and
// the shot is reported as a one-cycle hit or miss pulse.
//
// Optional feature macro: ZAPPER_BLACK_CHECK_EN
//   defined   : light seen during the black frame flags a cheat (gun aimed at
//               a lamp) and forces the shot to report miss.
//   undefined : black-frame light is ignored.
//
// Handshake: there is no valid/ready pair here. frame_start is a one-cycle
// strobe and valid a level, both from the vga timing block. blank_req and
// target_req are levels that pattern_gen follows for as long as they are high.
// hit and miss are one-cycle strobes with no back-pressure.

module zapper_hit_detector #(
  parameter int DEBOUNCE_CYCLES  = 250000,
  parameter int TARGET_FRAMES    = 1,
  parameter int LIGHT_MIN        = 16,
  parameter int LIGHT_ACTIVE_LOW = 1,
  parameter int CNT_W            = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic trigger,
  input  logic light,
  input  logic frame_start,
  input  logic valid,
  output logic blank_req,
  output logic target_req,
  output logic busy,
  output logic hit,
  output logic miss
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_FRAME = 3'd1,
    BLACK      = 3'd2,
    TARGET     = 3'd3,
    RESULT     = 3'd4,
    RELEASE    = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(TARGET_FRAMES - 1);
  localparam logic [CNT_W-1:0] LIGHT_THR  = CNT_W'(LIGHT_MIN);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic             LIGHT_INV  = (LIGHT_ACTIVE_LOW != 0);

  state_t           state;
  logic [1:0]       trig_sync;
  logic [1:0]       light_sync;
  logic             trig_s;
  logic             light_s;
  logic [CNT_W-1:0] db_cnt;
  logic             trig_db;
  logic             trig_db_q;
  logic             shot;
  logic [CNT_W-1:0] light_cnt;
  logic [CNT_W-1:0] light_cnt_inc;
  logic [CNT_W-1:0] frame_cnt;
  logic             lit;
  logic             light_ok;
  logic             frame_last;
`ifdef ZAPPER_BLACK_CHECK_EN
  logic             cheat;
`endif

  // Two-flop synchronizers for both asynchronous pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_sync  <= 2'b00;
      light_sync <= 2'b00;
    end else begin
      trig_sync  <= {trig_sync[0], trigger};
      light_sync <= {light_sync[0], light};
    end
  end

  assign trig_s  = trig_sync[1];
  assign light_s = light_sync[1] ^ LIGHT_INV;

  // Debounce: trig_db follows trig_s only after DEBOUNCE_CYCLES consecutive
  // cycles of disagreement. trig_db resets high so that a trigger held
  // through reset has to be released and pulled again before it fires.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt  <= '0;
      trig_db <= 1'b1;
    end else if (trig_s == trig_db) begin
      db_cnt  <= '0;
    end else if (db_cnt >= DB_LAST) begin
      db_cnt  <= '0;
      trig_db <= trig_s;
    end else begin
      db_cnt  <= db_cnt + 1'b1;
    end
  end

  // Previous debounced level, used to detect the rising edge that is a shot.
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_db_q <= 1'b1;
    end else begin
      trig_db_q <= trig_db;
    end
  end

  assign shot = trig_db & ~trig_db_q;

  // A lit visible pixel. The count saturates rather than wrapping, so a long
  // bright exposure can never turn back into a miss.
  assign lit           = valid & light_s;
  assign light_cnt_inc = (lit && (light_cnt != CNT_MAX)) ? light_cnt + 1'b1 : light_cnt;
  // Uses the incremented count: a sample taken on the closing frame_start
  // still belongs to the target frame that is ending.
  assign light_ok      = (light_cnt_inc >= LIGHT_THR);
  assign frame_last    = (frame_cnt == FRAME_LAST);

  // Shot sequencer. hit, miss and busy are registered together with the
  // state, so hit and miss are high exactly during the single RESULT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      light_cnt <= '0;
      frame_cnt <= '0;
      busy      <= 1'b0;
      hit       <= 1'b0;
      miss      <= 1'b0;
`ifdef ZAPPER_BLACK_CHECK_EN
      cheat     <= 1'b0;
`endif
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      case (state)
        IDLE: begin
          if (shot) begin
            state <= WAIT_FRAME;
            busy  <= 1'b1;
          end
        end

        // The frame in progress when the shot arrived is never used.
        WAIT_FRAME: begin
          if (frame_start) begin
            state <= BLACK;
`ifdef ZAPPER_BLACK_CHECK_EN
            cheat <= 1'b0;
`endif
          end
        end

        BLACK: begin
`ifdef ZAPPER_BLACK_CHECK_EN
          if (lit) begin
            cheat <= 1'b1;
          end
`endif
          if (frame_start) begin
            state     <= TARGET;
            light_cnt <= '0;
            frame_cnt <= '0;
          end
        end

        TARGET: begin
          light_cnt <= light_cnt_inc;
          if (frame_start) begin
            if (frame_last) begin
              state <= RESULT;
`ifdef ZAPPER_BLACK_CHECK_EN
              hit   <= light_ok & ~cheat;
              miss  <= ~light_ok | cheat;
`else
              hit   <= light_ok;
              miss  <= ~light_ok;
`endif
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end

        RESULT: begin
          state <= RELEASE;
        end

        // One shot per pull: the trigger must be released before re-arming.
        RELEASE: begin
          if (!trig_db) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Frame requests to pattern_gen follow the state directly.
  assign blank_req  = (state == BLACK);
  assign target_req = (state == TARGET);

endmodule

// File: tb/tb_zapper_hit_detector.sv
// tb_zapper_hit_detector
// Directed and randomized shots against a frame-level reference model.
// Optional feature macro: ZAPPER_BLACK_CHECK_EN (changes the expected cheat result).

module tb_zapper_hit_detector;

  localparam int DB   = 4;
  localparam int TF   = 1;
  localparam int LMIN = 3;
  localparam int LAL  = 1;
`ifdef ZAPPER_BLACK_CHECK_EN
  localparam bit CHEAT_EN = 1'b1;
`else
  localparam bit CHEAT_EN = 1'b0;
`endif

  // clock / reset / pins
  logic clk = 1'b0;
  logic reset, trigger, light, frame_start, valid;
  logic blank_req, target_req, busy, hit, miss;

  always #5 clk = ~clk;

  zapper_hit_detector #(
    .DEBOUNCE_CYCLES (DB),
    .TARGET_FRAMES   (TF),
    .LIGHT_MIN       (LMIN),
    .LIGHT_ACTIVE_LOW(LAL),
    .CNT_W           (20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .trigger    (trigger),
    .light      (light),
    .frame_start(frame_start),
    .valid      (valid),
    .blank_req  (blank_req),
    .target_req (target_req),
    .busy       (busy),
    .hit        (hit),
    .miss       (miss)
  );

  // scoreboard state
  int   n_eval = 0;
  int   n_fail = 0;
  bit   in_black  = 1'b0;
  bit   in_target = 1'b0;
  int   cnt = 0;
  bit   cheat = 1'b0;
  logic l_d1 = 1'b1;
  logic l_d2 = 1'b1;
  logic [0:0] exp_q[$];

  // pulse monitors, sampled on the falling edge
  int   hit_pulses = 0;
  int   miss_pulses = 0;
  int   busy_rises = 0;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    if (hit === 1'b1) hit_pulses++;
    if (miss === 1'b1) miss_pulses++;
    if (busy === 1'b1 && busy_prev !== 1'b1) busy_rises++;
    busy_prev = busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle. The photodiode reaches the detector two cycles late,
  // so a sample is lit when valid is high now and the pin was low two cycles ago.
  task automatic step(input logic fs, input logic v, input logic l);
    bit lit_now;
    frame_start = fs;
    valid = v;
    light = l;
    @(posedge clk);
    lit_now = v && (l_d2 == 1'b0);
    if (in_target && lit_now) cnt++;
    if (in_black && lit_now) cheat = 1'b1;
    l_d2 = l_d1;
    l_d1 = l;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b1);
  endtask

  task automatic pull(input string tag);
    trigger = 1'b1;
    idle(12);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_noblank"}, blank_req, 0);
  endtask

  task automatic release_trig(input string tag);
    trigger = 1'b0;
    idle(12);
    chk({tag, "_idle"}, busy, 0);
  endtask

  // Target-frame light pattern for cycle i of a frame of tlen cycles
  // (i == tlen is the closing frame_start cycle).
  task automatic pat(input int mode, input int i, input int tlen, output logic v, output logic l);
    case (mode)
      1: begin v = 1'b1; l = (i >= 2 && i < 7) ? 1'b0 : 1'b1; end
      2: begin v = 1'b1; l = (i >= 2 && i < 4) ? 1'b0 : 1'b1; end
      3: begin v = 1'b0; l = 1'b0; end
      4: begin v = 1'b1; l = 1'b0; end
      5: begin v = 1'b1; l = (i >= tlen - 4 && i <= tlen - 2) ? 1'b0 : 1'b1; end
      6: begin v = 1'b1; l = (i >= tlen - 2 && i <= tlen) ? 1'b0 : 1'b1; end
      default: begin
        v = 1'($urandom_range(0, 1));
        l = ($urandom_range(0, 5) != 0);
      end
    endcase
  endtask

  // Black frame of blen cycles, target frame of tlen cycles, result check.
  task automatic shot(input string tag, input int blen, input int tlen,
                      input bit black_lit, input int tmode);
    logic v, l;
    int   hp0, mp0;
    logic [0:0] exp_hit;
    hp0 = hit_pulses;
    mp0 = miss_pulses;
    cheat = 1'b0;
    step(1'b1, 1'b0, black_lit ? 1'b0 : 1'b1);
    in_black = 1'b1;
    chk({tag, "_blank"}, blank_req, 1);
    chk({tag, "_blank_tgt"}, target_req, 0);
    for (int i = 1; i < blen; i++) begin
      if (black_lit) step(1'b0, 1'b1, 1'b0);
      else step(1'b0, 1'($urandom_range(0, 1)), 1'b1);
    end
    pat(tmode, 0, tlen, v, l);
    step(1'b1, v, l);
    in_black = 1'b0;
    cnt = 0;
    in_target = 1'b1;
    chk({tag, "_target"}, target_req, 1);
    chk({tag, "_target_blank"}, blank_req, 0);
    for (int i = 1; i < tlen; i++) begin
      pat(tmode, i, tlen, v, l);
      step(1'b0, v, l);
    end
    chk({tag, "_early_hit"}, hit, 0);
    chk({tag, "_early_miss"}, miss, 0);
    pat(tmode, tlen, tlen, v, l);
    step(1'b1, v, l);
    in_target = 1'b0;
    exp_q.push_back(((cnt >= LMIN) && !(CHEAT_EN && cheat)) ? 1'b1 : 1'b0);
    exp_hit = exp_q.pop_front();
    chk({tag, "_hit"}, hit, exp_hit);
    chk({tag, "_miss"}, miss, !exp_hit);
    chk({tag, "_res_tgt"}, target_req, 0);
    step(1'b0, 1'b0, 1'b1);
    chk({tag, "_hit_once"}, hit_pulses - hp0, exp_hit);
    chk({tag, "_miss_once"}, miss_pulses - mp0, !exp_hit);
    chk({tag, "_hold_busy"}, busy, 1);
  endtask

  initial begin
    int br0, hp0, mp0;
    logic v, l;
    reset = 1'b1;
    trigger = 1'b0;
    light = 1'b1;
    frame_start = 1'b0;
    valid = 1'b0;
    repeat (3) step(1'b0, 1'b0, 1'b1);
    chk("rst_busy", busy, 0);
    chk("rst_blank", blank_req, 0);
    chk("rst_target", target_req, 0);
    chk("rst_hit", hit, 0);
    chk("rst_miss", miss, 0);
    reset = 1'b0;
    idle(12);
    chk("post_rst_busy", busy, 0);

    // bouncing trigger settles into a single shot
    br0 = busy_rises;
    for (int k = 0; k < 10; k++) begin
      trigger = ~trigger;
      idle(2);
    end
    chk("bounce_quiet", busy, 0);
    pull("bounce");
    shot("bounce_hit", 20, 20, 1'b0, 1);
    chk("bounce_one_rise", busy_rises - br0, 1);
    release_trig("bounce");

    pull("miss2");
    shot("miss2", 15, 20, 1'b0, 2);
    release_trig("miss2");

    pull("blind");
    shot("blind", 15, 20, 1'b0, 3);
    release_trig("blind");

    pull("edge3");
    shot("edge3", 12, 16, 1'b0, 5);
    release_trig("edge3");

    pull("late");
    shot("late", 12, 16, 1'b0, 6);
    release_trig("late");

    // lit throughout black and target; then hold the trigger
    pull("cheat");
    shot("cheat", 15, 15, 1'b1, 4);
    br0 = busy_rises;
    hp0 = hit_pulses;
    mp0 = miss_pulses;
    idle(30);
    chk("hold_busy", busy, 1);
    chk("hold_no_shot", busy_rises - br0, 0);
    chk("hold_no_pulse", (hit_pulses - hp0) + (miss_pulses - mp0), 0);
    release_trig("hold");
    pull("repull");
    chk("repull_rise", busy_rises - br0, 1);
    shot("repull", 10, 14, 1'b0, 1);
    release_trig("repull");

    // reset in the middle of a target frame with the trigger held
    pull("mid_rst");
    step(1'b1, 1'b0, 1'b1);
    repeat (8) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
    chk("mid_rst_in_target", target_req, 1);
    hp0 = hit_pulses;
    mp0 = miss_pulses;
    reset = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_target", target_req, 0);
    chk("mid_rst_blank", blank_req, 0);
    chk("mid_rst_hit", hit, 0);
    chk("mid_rst_miss", miss, 0);
    step(1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    br0 = busy_rises;
    for (int i = 0; i < 20; i++) begin
      pat(0, i, 20, v, l);
      step(1'(i == 5), v, 1'b1);
    end
    chk("mid_rst_no_shot", busy_rises - br0, 0);
    chk("mid_rst_no_pulse", (hit_pulses - hp0) + (miss_pulses - mp0), 0);
    chk("mid_rst_idle", busy, 0);
    release_trig("mid_rst_rel");
    pull("after_rst");
    shot("after_rst", 10, 14, 1'b0, 1);
    release_trig("after_rst");

    // randomized shots
    for (int r = 0; r < 8; r++) begin
      pull("rnd");
      shot("rnd", $urandom_range(6, 25), $urandom_range(12, 45), 1'b0, 0);
      release_trig("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
